// File: rtl/if_pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: next-PC select codes
// and default address map.
package if_pc_gen_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_LO_DEFAULT    = 32'h0000_3000;
  localparam logic [31:0] PC_HI_DEFAULT    = 32'h0000_4FFC;

endpackage

// File: rtl/if_pc_gen_npc_calc.sv
// Combinational next-PC selection: sequential, branch, j/jal and jr targets,
// plus the PC+4 / PC+8 values derived from the current fetch PC.
module npc_calc
  import if_pc_gen_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic [31:0] id_pc4,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_data,
  output logic [31:0] npc,
  output logic [31:0] pc4,
  output logic [31:0] pc8
);

  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign pc4       = pc + 32'd4;
  assign pc8       = pc + 32'd8;
  // Branch offset is relative to the branch's own PC+4 (delay-slot semantics).
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_target = id_pc4 + br_offset;
  assign j_target  = {id_pc4[31:28], index26, 2'b00};

  always_comb begin
    npc = pc4;
    case (npc_op)
      NPC_SEQ: npc = pc4;
      NPC_BR:  npc = br_target;
      NPC_J:   npc = j_target;
      NPC_JR:  npc = rs_data;
      default: npc = pc4;
    endcase
  end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch PC register and fetch counter for the five-stage pipeline.
// Optional feature macro: IFU_PC_RANGE_CHECK_EN (address range/alignment check with hold).
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_LO    = PC_LO_DEFAULT,
  parameter logic [31:0] PC_HI    = PC_HI_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [1:0]  NPCOp,
  input  logic [31:0] ID_PC4,
  input  logic [15:0] Imm16,
  input  logic [25:0] Index26,
  input  logic [31:0] RsData,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] PC8,
  output logic [31:0] FetchCnt,
  output logic        PCErr
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] fetch_cnt_reg;
  logic        pc_err;
  logic        hold;

  npc_calc u_npc_calc (
    .pc      (pc_reg),
    .npc_op  (NPCOp),
    .id_pc4  (ID_PC4),
    .imm16   (Imm16),
    .index26 (Index26),
    .rs_data (RsData),
    .npc     (pc_next),
    .pc4     (PC4),
    .pc8     (PC8)
  );

`ifdef IFU_PC_RANGE_CHECK_EN
  assign pc_err = (pc_reg < PC_LO) || (pc_reg > PC_HI) || (pc_reg[1:0] != 2'b00);
  // A bad fetch address freezes the front end until the next reset.
  assign hold   = Stall || pc_err;
`else
  logic unused_range;
  assign unused_range = ^{PC_LO, PC_HI};
  assign pc_err       = 1'b0;
  assign hold         = Stall;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_reg        <= RESET_PC;
      fetch_cnt_reg <= 32'd0;
    end else if (!hold) begin
      pc_reg        <= pc_next;
      fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
    end
  end

  assign PC       = pc_reg;
  assign FetchCnt = fetch_cnt_reg;
  assign PCErr    = pc_err;

endmodule

// File: doc/if_pc_gen.md
# if_pc_gen

Fetch-stage program counter generator for the five-stage MIPS pipeline. Holds the architectural fetch PC, computes the next PC (sequential, branch, j/jal, jr) from decode-stage redirect information, and drives the word address of the instruction memory directly downstream. Honours pipeline stalls from the hazard unit and keeps a free-running count of issued fetches for the testbench and debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset
- PC_LO, 32'h0000_3000, lowest legal fetch address (range check only)
- PC_HI, 32'h0000_4FFC, highest legal fetch address (range check only)

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Stall  in  1  hold PC and counter this cycle (hazard unit)
- NPCOp  in  2  next-PC select: 00 seq, 01 branch, 10 j/jal, 11 jr
- ID_PC4  in  32  PC+4 of the instruction currently in decode
- Imm16  in  16  branch offset field of decode instruction
- Index26  in  26  jump target field of decode instruction
- RsData  in  32  forwarded rs value for jr/jalr
- PC  out  32  current fetch PC; PC[12:2] feeds instruction memory Addr
- PC4  out  32  PC + 4, registered into IF/ID
- PC8  out  32  PC + 8, link address for jal/jalr
- FetchCnt  out  32  number of PC advances since reset
- PCErr  out  1  fetch address outside [PC_LO, PC_HI] or misaligned

## Operation
- PC register is the only architectural state; PC4/PC8 are combinational from PC.
- Next-PC (NPC), evaluated every cycle:
  - 00: PC + 4
  - 01: ID_PC4 + (sign_extend(Imm16) << 2)  (delay-slot semantics: offset relative to branch PC+4)
  - 10: {ID_PC4[31:28], Index26, 2'b00}
  - 11: RsData (used unmodified, no alignment forcing)
- Update priority on rising Clk: Reset > Stall > NPC load.
  - Reset: PC <= RESET_PC, FetchCnt <= 0.
  - Stall: PC and FetchCnt hold; NPCOp ignored this cycle (decode holds the branch and re-asserts next cycle).
  - Otherwise: PC <= NPC, FetchCnt <= FetchCnt + 1.
- Redirect in decode does not squash the instruction already fetched (delay slot executes); no flush output.
- All additions are 32-bit modulo 2^32; PC + 4 at 32'hFFFF_FFFC wraps to 0, FetchCnt wraps 32'hFFFF_FFFF -> 0.
- Reset asserted mid-stall or mid-redirect: reset wins unconditionally, next cycle PC = RESET_PC.

## Timing
- Reset values: PC = RESET_PC, PC4 = RESET_PC+4, PC8 = RESET_PC+8, FetchCnt = 0, PCErr = 0 (for default parameters).
- NPC to PC latency: one cycle; redirect presented in cycle n appears on PC after edge n.
- PC to instruction memory Addr: same cycle, combinational.
- Stall is level-sensitive; a stall of k cycles holds PC for exactly k edges.
- PCErr is combinational from PC, valid in the same cycle as the offending PC.

## Configuration
- IFU_PC_RANGE_CHECK_EN defined: PCErr = 1 when PC < PC_LO, PC > PC_HI, or PC[1:0] != 0; PC still loads the bad value (no trapping); additionally, while PCErr is 1 the PC is held as if Stall were asserted (FetchCnt also holds) until Reset.
- Not defined: PCErr tied to 0, no hold, PC_LO/PC_HI unused.

## Structure
- Shared package/header: NPCOp encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR), RESET_PC default.
- One sub-module natural: npc_calc (purely combinational next-PC mux and adders); if_pc_gen instantiates it plus the PC and FetchCnt registers.

## Test plan
- Reset held 2 cycles, then NPCOp=00 for 3 cycles -> PC 0x3000, 0x3004, 0x3008, 0x300C; FetchCnt 0,1,2,3; PC8 = 0x3014 at last.
- NPCOp=01, ID_PC4=0x3008, Imm16=16'hFFFE -> next PC 0x3000; Imm16=16'h0003 -> 0x3014.
- NPCOp=10, ID_PC4=0x3010, Index26=26'h0000C10 -> next PC 0x3040; NPCOp=11, RsData=0x3100 -> 0x3100.
- Stall high 3 cycles with NPCOp=01 asserted -> PC and FetchCnt unchanged for 3 edges; redirect taken on first edge after Stall drops.
- Reset asserted together with Stall and NPCOp=11 at PC=0x3100 -> PC = 0x3000, FetchCnt = 0 next cycle.
- With IFU_PC_RANGE_CHECK_EN: NPCOp=11, RsData=0x5000 -> PC=0x5000, PCErr=1, PC holds until Reset; RsData=0x3002 -> PCErr=1. Without macro: same stimulus -> PCErr=0, PC advances to 0x5004.
